// File: rtl/bus_interconnect_n_pkg.sv
// Shared definitions for the data-bus interconnect: FSM encoding, SoC region map, error data.
package bus_interconnect_n_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } bus_state_e;

  // Read data returned alongside cpu_err unless the instance overrides it.
  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'h0000_0000;

  // SoC region map, slice i = region i. Lower index wins on overlap.
  localparam int unsigned SOC_NUM_REGIONS = 5;

  localparam logic [SOC_NUM_REGIONS*32-1:0] SOC_SLAVE_BASE = {
    32'h4000_0000,  // counters
    32'h3000_0000,  // uart
    32'h2000_0000,  // flash
    32'h1000_0000,  // screen
    32'h0000_0000   // ram
  };

  localparam logic [SOC_NUM_REGIONS*32-1:0] SOC_SLAVE_MASK = {
    32'hFFFF_FF00,
    32'hFFFF_FF00,
    32'hFF00_0000,
    32'hFFF0_0000,
    32'hFFFF_0000
  };

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational base/mask address decoder with lowest-index priority and optional default slave.
module bus_addr_decoder
  import bus_interconnect_n_pkg::*;
#(
  parameter int unsigned                  NUM_SLAVES    = 8,
  parameter logic [NUM_SLAVES*32-1:0]     SLAVE_BASE    = '0,
  parameter logic [NUM_SLAVES*32-1:0]     SLAVE_MASK    = '0,
  parameter int unsigned                  DEFAULT_SLAVE = NUM_SLAVES
) (
  input  logic [31:0]                        addr,
  output logic                               hit,
  output logic [$clog2(NUM_SLAVES+1)-1:0]    idx
);

  localparam int unsigned IDX_W = $clog2(NUM_SLAVES + 1);

  // Scan from the top index down so the lowest matching region is the one left standing.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
    if (!hit && (DEFAULT_SLAVE < NUM_SLAVES)) begin
      hit = 1'b1;
      idx = IDX_W'(DEFAULT_SLAVE);
    end
  end

endmodule

// File: rtl/bus_interconnect_n.sv
// Routes one CPU data port to NUM_SLAVES regions with ready handshake, timeout and held response.
module bus_interconnect_n
  import bus_interconnect_n_pkg::*;
#(
  parameter int unsigned              NUM_SLAVES     = 8,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE     = '0,
  parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK     = '0,
  parameter int unsigned              DEFAULT_SLAVE  = NUM_SLAVES,
  parameter int unsigned              TIMEOUT_CYCLES = 255,
  parameter logic [31:0]              ERR_RDATA      = DEFAULT_ERR_RDATA
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cpu_req,
  input  logic                       cpu_wen,
  input  logic [31:0]                cpu_addr,
  input  logic [31:0]                cpu_wdata,
  input  logic [3:0]                 cpu_wstrb,
  input  logic                       cpu_stall,
  output logic                       cpu_busy,
  output logic                       cpu_ack,
  output logic                       cpu_err,
  output logic [31:0]                cpu_rdata,
  output logic [NUM_SLAVES-1:0]      s_ren,
  output logic [NUM_SLAVES-1:0]      s_wen,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wdata,
  output logic [3:0]                 s_wstrb,
  input  logic [NUM_SLAVES*32-1:0]   s_rdata,
  input  logic [NUM_SLAVES-1:0]      s_ready
);

  localparam int unsigned      IDX_W    = $clog2(NUM_SLAVES + 1);
  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  bus_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             wen_q, wen_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

  logic             dec_hit;
  logic [IDX_W-1:0] dec_idx;
  logic             sel_ready;
  logic [31:0]      sel_rdata;

  bus_addr_decoder #(
    .NUM_SLAVES    (NUM_SLAVES),
    .SLAVE_BASE    (SLAVE_BASE),
    .SLAVE_MASK    (SLAVE_MASK),
    .DEFAULT_SLAVE (DEFAULT_SLAVE)
  ) u_dec (
    .addr (cpu_addr),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  // Pick ready and read data of the latched slave; other slaves' ready is ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_ready = s_ready[i];
        sel_rdata = s_rdata[i*32 +: 32];
      end
    end
  end

  // Next-state logic: accept in idle, wait for ready or timeout, hold response while stalled.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          if (dec_hit) begin
            idx_d   = dec_idx;
            wen_d   = cpu_wen;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
            wstrb_d = cpu_wstrb;
            cnt_d   = '0;
            state_d = StAccess;
          end else begin
            rdata_d = ERR_RDATA;
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StAccess: begin
        // Ready on the final timeout cycle still wins.
        if (sel_ready) begin
          rdata_d = wen_q ? 32'h0 : sel_rdata;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q >= CNT_LAST) begin
          rdata_d = ERR_RDATA;
          err_d   = 1'b1;
          state_d = StResp;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StResp: begin
        if (!cpu_stall) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and latched transaction fields; async reset abandons any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Strobes decode from registered state only, so they drop as soon as reset asserts.
  always_comb begin
    s_ren = '0;
    s_wen = '0;
    if (state_q == StAccess) begin
      for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
        if (idx_q == IDX_W'(i)) begin
          s_ren[i] = ~wen_q;
          s_wen[i] = wen_q;
        end
      end
    end
  end

  assign cpu_busy  = (state_q != StIdle);
  assign cpu_ack   = (state_q == StResp);
  assign cpu_err   = err_q;
  assign cpu_rdata = rdata_q;
  assign s_addr    = addr_q;
  assign s_wdata   = wdata_q;
  assign s_wstrb   = wstrb_q;

endmodule

// File: tb/tb_bus_interconnect_n.sv
// Self-checking bench for bus_interconnect_n: directed cases then random transactions.
module tb_bus_interconnect_n;

  localparam int unsigned NS  = 4;
  localparam int unsigned TO  = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  localparam logic [NS*32-1:0] BASES = {32'h2000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] MASKS = {32'hF000_0000, 32'hFFFF_0000, 32'hF000_0000, 32'hFFFF_0000};

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req, cpu_wen, cpu_stall;
  logic [31:0]       cpu_addr, cpu_wdata;
  logic [3:0]        cpu_wstrb;
  logic              cpu_busy, cpu_ack, cpu_err;
  logic [31:0]       cpu_rdata;
  logic [NS-1:0]     s_ren, s_wen, s_ready;
  logic [31:0]       s_addr, s_wdata;
  logic [3:0]        s_wstrb;
  logic [NS*32-1:0]  s_rdata;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] base_a [NS];
  logic [31:0] mask_a [NS];

  bus_interconnect_n #(
    .NUM_SLAVES     (NS),
    .SLAVE_BASE     (BASES),
    .SLAVE_MASK     (MASKS),
    .DEFAULT_SLAVE  (NS),
    .TIMEOUT_CYCLES (TO),
    .ERR_RDATA      (ERR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_wen   (cpu_wen),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_wstrb (cpu_wstrb),
    .cpu_stall (cpu_stall),
    .cpu_busy  (cpu_busy),
    .cpu_ack   (cpu_ack),
    .cpu_err   (cpu_err),
    .cpu_rdata (cpu_rdata),
    .s_ren     (s_ren),
    .s_wen     (s_wen),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_rdata   (s_rdata),
    .s_ready   (s_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode: first region whose masked address equals its base, else miss (-1).
  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++) begin
      if ((a & mask_a[i]) == base_a[i]) return i;
    end
    return -1;
  endfunction

  // One transaction: wait_n idle ACCESS cycles before ready (>= TO means never), stall_n stalled
  // RESP cycles before release. Slave read data must be loaded by the caller beforehand.
  task automatic do_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int wait_n, input int stall_n);
    int          e;
    int          exp_strb;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  oh;
    int          k;
    e        = ref_decode(addr);
    exp_err  = (e < 0) || (wait_n >= TO);
    exp_strb = (e < 0) ? 0 : ((wait_n < TO) ? wait_n + 1 : TO);
    oh       = (e < 0) ? 4'b0 : 4'(1 << e);
    if (exp_err)  exp_rdata = ERR;
    else if (wen) exp_rdata = 32'h0;
    else          exp_rdata = s_rdata[e*32 +: 32];
    check("idle_busy", 32'(cpu_busy), 32'd0);
    check("idle_ack", 32'(cpu_ack), 32'd0);
    cpu_req = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata; cpu_wstrb = wstrb;
    s_ready = '0;
    @(negedge clk);
    // Scramble CPU-side fields to show the slave-side copies are latched.
    cpu_req = 1'b0; cpu_addr = $urandom; cpu_wdata = $urandom; cpu_wstrb = 4'($urandom);
    k = 0;
    while (!cpu_ack && k < TO + 4) begin
      check("strobe", 32'({s_wen, s_ren}), 32'(wen ? {oh, 4'b0} : {4'b0, oh}));
      check("s_addr", s_addr, addr);
      check("s_wdata", s_wdata, wdata);
      check("s_wstrb", 32'(s_wstrb), 32'(wstrb));
      s_ready = 4'($urandom) & ~oh;
      if (k == wait_n) s_ready = s_ready | oh;
      k++;
      @(negedge clk);
    end
    s_ready = '0;
    check("ack_latency", 32'(k), 32'(exp_strb));
    for (int j = 0; j <= stall_n; j++) begin
      check("resp_ack", 32'(cpu_ack), 32'd1);
      check("resp_busy", 32'(cpu_busy), 32'd1);
      check("resp_err", 32'(cpu_err), 32'(exp_err));
      check("resp_rdata", cpu_rdata, exp_rdata);
      check("resp_strobe", 32'({s_wen, s_ren}), 32'd0);
      if (e >= 0) check("resp_s_addr", s_addr, addr);
      cpu_stall = (j < stall_n);
      cpu_req   = 1'($urandom);
      for (int i = 0; i < NS; i++) s_rdata[i*32 +: 32] = $urandom;
      s_ready   = 4'($urandom);
      @(negedge clk);
    end
    cpu_req = 1'b0; cpu_stall = 1'b0; s_ready = '0;
    check("back_idle_ack", 32'(cpu_ack), 32'd0);
    check("back_idle_busy", 32'(cpu_busy), 32'd0);
  endtask

  task automatic load_slaves();
    for (int i = 0; i < NS; i++) s_rdata[i*32 +: 32] = $urandom;
  endtask

  initial begin
    logic [31:0] a;
    logic        w;
    for (int i = 0; i < NS; i++) begin
      base_a[i] = BASES[i*32 +: 32];
      mask_a[i] = MASKS[i*32 +: 32];
    end
    rst = 1'b1; cpu_req = 1'b0; cpu_wen = 1'b0; cpu_stall = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0; s_ready = '0; s_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(cpu_busy), 32'd0);
    check("rst_ack", 32'(cpu_ack), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_strobe", 32'({s_wen, s_ren}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait read of slave 0.
    load_slaves(); s_rdata[31:0] = 32'hCAFE_BABE;
    do_txn(1'b0, 32'h0000_0010, 32'h0, 4'hF, 0, 0);
    // Write to slave 1 with three wait cycles.
    load_slaves();
    do_txn(1'b1, 32'h1000_0004, 32'h1234_5678, 4'b0011, 3, 0);
    // Unmapped address: immediate error response.
    do_txn(1'b0, 32'hF000_0000, 32'h0, 4'hF, 0, 0);
    // Overlap resolves to slave 2; never ready -> timeout.
    load_slaves();
    do_txn(1'b0, 32'h2000_1234, 32'h0, 4'hF, 100, 0);
    // Slave 3 ready on the final timeout cycle -> normal response.
    load_slaves();
    do_txn(1'b0, 32'h2100_0000, 32'h0, 4'hF, TO - 1, 0);
    // Response held across a stall while slave data churns.
    load_slaves();
    do_txn(1'b0, 32'h0000_0400, 32'h0, 4'hF, 1, 4);

    // Reset in the second ACCESS cycle of a stuck access.
    load_slaves();
    cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h0000_0020;
    @(negedge clk);
    cpu_req = 1'b0;
    check("pre_rst_strobe", 32'(s_ren), 32'd1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_rst_strobe", 32'({s_wen, s_ren}), 32'd0);
    check("async_rst_busy", 32'(cpu_busy), 32'd0);
    check("async_rst_ack", 32'(cpu_ack), 32'd0);
    check("async_rst_rdata", cpu_rdata, 32'd0);
    check("async_rst_s_addr", s_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load_slaves();
    do_txn(1'b0, 32'h1000_0100, 32'h0, 4'hF, 0, 0);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0:       a = {16'h0000, 16'($urandom)};
        1:       a = {4'h1, 28'($urandom)};
        2:       a = {16'h2000, 16'($urandom)};
        3:       a = {4'h2, 28'($urandom)};
        default: a = $urandom;
      endcase
      w = 1'($urandom);
      load_slaves();
      do_txn(w, a, $urandom, 4'($urandom), int'($urandom_range(0, TO + 1)),
             int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
